// File: rtl/cobs_decode_wrapper_if.sv
// ---------------------------------------------------------------------------
// cobs_decode_wrapper_if
//   Byte-wide AXI-Stream bundle used on both sides of the COBS decoder.
//
//   Signals : tdata  - stream byte
//             tvalid - byte valid
//             tready - sink accepts byte
//             tlast  - last byte of frame
//             tuser  - frame error (qualified by tlast)
//   Modports: master - drives tdata/tvalid/tlast/tuser, receives tready
//             slave  - receives tdata/tvalid/tlast/tuser, drives tready
// ---------------------------------------------------------------------------
interface cobs_decode_wrapper_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/cobs_decode_wrapper.sv
// ---------------------------------------------------------------------------
// cobs_decode_wrapper
//   Streaming COBS decoder. Consumes COBS-encoded bytes (0x00 = frame
//   delimiter) and emits the raw payload with tlast on the final byte of
//   each frame and tuser=1 on that byte when the frame was malformed
//   (truncated block or payload longer than MAX_FRAME_LEN).
//
//   Ports:
//     clk        system clock
//     rst        asynchronous active-low reset (release synchronously)
//     s_axis     slave stream of encoded bytes (tlast/tuser ignored)
//     m_axis     master stream of decoded bytes
//     err_count  [15:0] saturating malformed/empty frame count
//                (present only when COBS_DECODE_ERR_CNT_EN is defined)
//
//   Optional feature macro: COBS_DECODE_ERR_CNT_EN
//
//   Each decoded byte is parked in a one-entry hold register and only
//   forwarded when the next decoded byte or the delimiter arrives, so the
//   delimiter can tag the true last byte with tlast.
// ---------------------------------------------------------------------------
module cobs_decode_wrapper #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    cobs_decode_wrapper_if.slave  s_axis,
    cobs_decode_wrapper_if.master m_axis
`ifdef COBS_DECODE_ERR_CNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    generate
        if (DATA_WIDTH != 8) begin : g_width_check
            $fatal(1, "cobs_decode_wrapper: DATA_WIDTH must be 8");
        end
        if (MAX_FRAME_LEN < 2 || MAX_FRAME_LEN > 65535) begin : g_len_check
            $fatal(1, "cobs_decode_wrapper: MAX_FRAME_LEN must be 2..65535");
        end
    endgenerate

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    typedef enum logic {
        ST_EXPECT_CODE = 1'b0,
        ST_DATA        = 1'b1
    } state_t;

    // Registered state
    state_t      state_reg,        state_next;
    logic [7:0]  remaining_reg,    remaining_next;
    logic        block_max_reg,    block_max_next;
    logic        pending_zero_reg, pending_zero_next;
    logic        code_seen_reg,    code_seen_next;
    logic        frame_err_reg,    frame_err_next;
    logic [15:0] len_reg,          len_next;
    logic        hold_valid_reg,   hold_valid_next;
    logic [7:0]  hold_data_reg,    hold_data_next;
    logic        out_valid_reg,    out_valid_next;
    logic [7:0]  out_data_reg,     out_data_next;
    logic        out_last_reg,     out_last_next;
    logic        out_user_reg,     out_user_next;
`ifdef COBS_DECODE_ERR_CNT_EN
    logic [15:0] err_cnt_reg,      err_cnt_next;
`endif

    // Combinational helpers
    logic       s_ready;
    logic       accept;
    logic [7:0] in_byte;
    logic       in_zero;
    logic       push_req;
    logic [7:0] push_byte;
    logic       push_take;
    logic       push_drop;
    logic       len_full;
    logic       delim;
    logic       trunc;
    logic       end_err;

    // Framing is by 0x00 only; upstream tlast/tuser carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = s_axis.tlast ^ s_axis.tuser;

    assign in_byte = s_axis.tdata;
    assign in_zero = (in_byte == 8'h00);
    assign s_ready = !out_valid_reg || m_axis.tready;
    assign accept  = s_axis.tvalid && s_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : next_state_comb
        state_next = state_reg;
        if (accept) begin
            if (in_zero) begin
                state_next = ST_EXPECT_CODE;
            end else if (state_reg == ST_EXPECT_CODE) begin
                // Code 0x01 carries no data bytes, so the next byte is a code.
                state_next = (in_byte == 8'h01) ? ST_EXPECT_CODE : ST_DATA;
            end else if (remaining_reg == 8'd1) begin
                state_next = ST_EXPECT_CODE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output logic
    // ------------------------------------------------------------------
    always_comb begin : output_comb
        push_req          = 1'b0;
        push_byte         = 8'h00;
        delim             = 1'b0;
        trunc             = 1'b0;
        remaining_next    = remaining_reg;
        block_max_next    = block_max_reg;
        pending_zero_next = pending_zero_reg;
        code_seen_next    = code_seen_reg;

        if (accept) begin
            if (in_zero) begin
                delim             = 1'b1;
                trunc             = (state_reg == ST_DATA);
                // The implicit zero after the final block is never emitted.
                pending_zero_next = 1'b0;
                code_seen_next    = 1'b0;
            end else if (state_reg == ST_EXPECT_CODE) begin
                // A new code byte proves the previous block's implied zero
                // was real payload, so it is materialised now.
                push_req          = pending_zero_reg;
                push_byte         = 8'h00;
                remaining_next    = in_byte - 8'd1;
                block_max_next    = (in_byte == 8'hFF);
                pending_zero_next = (in_byte == 8'h01);
                code_seen_next    = 1'b1;
            end else begin
                push_req       = 1'b1;
                push_byte      = in_byte;
                remaining_next = remaining_reg - 8'd1;
                if (remaining_reg == 8'd1) begin
                    // 0xFF blocks have no implied trailing zero.
                    pending_zero_next = !block_max_reg;
                end
            end
        end

        len_full  = (len_reg >= MAX_LEN);
        push_take = push_req && !len_full;
        push_drop = push_req && len_full;
        end_err   = frame_err_reg || trunc;

        frame_err_next = delim ? 1'b0 : (frame_err_reg || push_drop);
        len_next       = delim ? 16'd0 : (push_take ? len_reg + 16'd1 : len_reg);

        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        if (delim) begin
            hold_valid_next = 1'b0;
        end else if (push_take) begin
            hold_valid_next = 1'b1;
            hold_data_next  = push_byte;
        end

        // accept implies the output register is free this cycle, so a load
        // never overwrites a byte the sink has not taken.
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_user_next  = out_user_reg;
        if (hold_valid_reg && (delim || push_take)) begin
            out_valid_next = 1'b1;
            out_data_next  = hold_data_reg;
            out_last_next  = delim;
            out_user_next  = delim && end_err;
        end else if (m_axis.tready) begin
            out_valid_next = 1'b0;
        end

`ifdef COBS_DECODE_ERR_CNT_EN
        err_cnt_next = err_cnt_reg;
        if (delim && (end_err || (!hold_valid_reg && code_seen_reg)) &&
            (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin : state_reg_proc
        if (!rst) begin
            state_reg        <= ST_EXPECT_CODE;
            remaining_reg    <= 8'd0;
            block_max_reg    <= 1'b0;
            pending_zero_reg <= 1'b0;
            code_seen_reg    <= 1'b0;
            frame_err_reg    <= 1'b0;
            len_reg          <= 16'd0;
            hold_valid_reg   <= 1'b0;
            hold_data_reg    <= 8'h00;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= 8'h00;
            out_last_reg     <= 1'b0;
            out_user_reg     <= 1'b0;
`ifdef COBS_DECODE_ERR_CNT_EN
            err_cnt_reg      <= 16'd0;
`endif
        end else begin
            state_reg        <= state_next;
            remaining_reg    <= remaining_next;
            block_max_reg    <= block_max_next;
            pending_zero_reg <= pending_zero_next;
            code_seen_reg    <= code_seen_next;
            frame_err_reg    <= frame_err_next;
            len_reg          <= len_next;
            hold_valid_reg   <= hold_valid_next;
            hold_data_reg    <= hold_data_next;
            out_valid_reg    <= out_valid_next;
            out_data_reg     <= out_data_next;
            out_last_reg     <= out_last_next;
            out_user_reg     <= out_user_next;
`ifdef COBS_DECODE_ERR_CNT_EN
            err_cnt_reg      <= err_cnt_next;
`endif
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_valid_reg;
    assign m_axis.tdata  = out_data_reg;
    assign m_axis.tlast  = out_last_reg;
    assign m_axis.tuser  = out_user_reg;
`ifdef COBS_DECODE_ERR_CNT_EN
    assign err_count     = err_cnt_reg;
`endif

endmodule

// File: doc/cobs_decode_wrapper.md
Name: cobs_decode_wrapper

Overview:
- Streaming COBS decoder: the receive-side counterpart of the COBS encode wrapper.
- Accepts an 8-bit AXI-Stream of COBS-encoded bytes in which 0x00 delimits frames.
- Emits the raw payload as an 8-bit AXI-Stream with tlast on the final byte of each frame and tuser flagging malformed frames.
- Sits between the byte-transport receiver and the sample-unpacking logic.

Parameters:
- DATA_WIDTH, 8, stream width; any other value is a fatal elaboration error.
- MAX_FRAME_LEN, 1024, maximum decoded payload bytes per frame; range 2..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk)
- s_axis_tdata  input  8  encoded byte
- s_axis_tvalid  input  1  encoded byte valid
- s_axis_tready  output  1  decoder accepts byte
- s_axis_tlast  input  1  ignored; framing is by 0x00 only
- m_axis_tdata  output  8  decoded byte
- m_axis_tvalid  output  1  decoded byte valid
- m_axis_tready  input  1  downstream accepts byte
- m_axis_tlast  output  1  last byte of frame
- m_axis_tuser  output  1  frame error; meaningful only with tlast

Behaviour:
- Reset values: all m_axis outputs 0; state EXPECT_CODE; hold register empty; pending_zero=0; length counter=0.
- s_axis_tready = !m_axis_tvalid || m_axis_tready.
- An input byte is consumed on s_axis_tvalid && s_axis_tready.
- Each consumed byte produces at most one decoded byte into a 1-entry hold register (hold_data, hold_err).
- When a new byte enters a full hold register, the old contents move to the output register with tlast=0.
- Consequence: a data byte appears on m_axis one accepted input byte later.
- Output register is held stable while m_axis_tvalid && !m_axis_tready.
- State EXPECT_CODE:
  - Byte 0x00 ends the frame (see delimiter rules).
  - Byte N (0x01..0xFF): if pending_zero, push 0x00 into hold; set remaining=N-1, block_max=(N==0xFF).
  - If remaining==0, pending_zero := !block_max and stay in EXPECT_CODE; otherwise go to DATA.
- State DATA:
  - Non-zero byte: push the byte; decrement remaining.
  - When remaining reaches 0, pending_zero := !block_max; go to EXPECT_CODE.
  - Byte 0x00 is a truncated block: set frame error and apply delimiter rules.
- Delimiter rules:
  - Pending zero is discarded (the trailing implicit zero is never emitted).
  - If hold is valid, it moves to output with tlast=1 and tuser=frame error.
  - If hold is empty, nothing is emitted: no zero-length packets.
  - Clear pending_zero, frame error and length counter; go to EXPECT_CODE.
- Length: the counter increments per pushed byte. Pushes beyond MAX_FRAME_LEN are discarded and set frame error; the frame's final byte then carries tuser=1.
- Simultaneous delimiter flush and downstream stall: the input is stalled by the s_axis_tready rule; no byte is lost or reordered.
- Reset mid-frame: the partial frame is discarded with no tlast emitted. The next frame begins with a fresh code byte.

Optional Feature:
- Macro: COBS_DECODE_ERR_CNT_EN
- Defined:
  - Adds output port err_count [15:0].
  - Saturating count of frames ended with frame error, plus delimiters arriving with hold empty after at least one code byte.
  - Reset value 0; increments in the cycle the delimiter is consumed.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Input 02 11 02 22 00, m_axis_tready=1 -> output 11,00,22; tlast only on 22; tuser=0.
- Input 01 00 -> no m_axis_tvalid at all; with COBS_DECODE_ERR_CNT_EN, err_count=1.
- Input FF then bytes 01..FE then 01 00 -> output 01..FE (254 bytes); no 0x00 inserted after the FF block; tlast on FE.
- Input 03 11 00 -> output 11 with tlast=1, tuser=1.
- Frame 02 11 02 22 00 with m_axis_tready toggling 1,0,0,1,... -> s_axis_tready tracks the stalls; output 11,00,22 unchanged and stable while stalled.
- Assert rst low after 03 11 accepted, release, then send 02 33 00 -> only 33 with tlast=1 emitted; all outputs 0 during reset.
